// File: rtl/sr_flag_pkg.sv
// Shared constants and helpers for the sr_flag_arbiter slice.
package sr_flag_pkg;

  localparam logic [1:0] OP_QUERY = 2'b00;
  localparam logic [1:0] OP_CLR   = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  // Width of a requester id; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Request/response bundle between control agents and sr_flag_arbiter.
interface sr_flag_arbiter_if
  import sr_flag_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 4,
  parameter int unsigned IDW  = id_width(NREQ)
);

  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_op;
  logic [IW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_old;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_idx,
    input  req_ready, rsp_valid, rsp_id, rsp_old, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_idx,
    output req_ready, rsp_valid, rsp_id, rsp_old, rsp_err
  );

endinterface

// File: rtl/sr_flag_cell.sv
// Single set/reset flag cell; synchronous reset, clear wins over set.
module sr_flag_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      if (r)      q_d = 1'b0;
      else if (s) q_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting set/clear/query commands onto a bank of SR flag cells.
// Optional error counter output err_cnt enabled by defining SR_FLAG_ERRCNT_EN.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 16,
  parameter int unsigned IW    = $clog2(NFLAG)
) (
  input  logic              clk,
  input  logic              reset,
  sr_flag_arbiter_if.slave  bus,
`ifdef SR_FLAG_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic [NFLAG-1:0]  flags
);

  localparam int unsigned IDW = id_width(NREQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_old_q, rsp_old_d;
  logic             rsp_err_q, rsp_err_d;

  logic             win_any;
  logic [IDW-1:0]   win_id;
  logic [1:0]       win_op;
  logic [IW-1:0]    win_idx;
  logic             grant;
  int unsigned      cand;

  logic [NFLAG-1:0] cell_en, cell_s, cell_r;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    win_op  = OP_QUERY;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_any && bus.req_valid[cand]) begin
        win_any = 1'b1;
        win_id  = IDW'(cand);
        win_op  = bus.req_op[2*cand +: 2];
        win_idx = bus.req_idx[IW*cand +: IW];
      end
    end
  end

  assign grant = win_any && !reset;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win_id] = 1'b1;
  end

  // Illegal ops never enable a cell, so s=r=1 cannot reach the bank.
  always_comb begin
    cell_en = '0;
    cell_s  = '0;
    cell_r  = '0;
    for (int unsigned j = 0; j < NFLAG; j++) begin
      if (grant && win_op != OP_ILL && 32'(win_idx) == j) begin
        cell_en[j] = 1'b1;
        cell_s[j]  = (win_op == OP_SET);
        cell_r[j]  = (win_op == OP_CLR);
      end
    end
  end

  for (genvar g = 0; g < NFLAG; g++) begin : g_cell
    sr_flag_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (cell_en[g]),
      .s     (cell_s[g]),
      .r     (cell_r[g]),
      .q     (flags[g])
    );
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = grant;
    rsp_id_d    = rsp_id_q;
    rsp_old_d   = rsp_old_q;
    rsp_err_d   = rsp_err_q;
    if (grant) begin
      ptr_d     = (32'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
      rsp_id_d  = win_id;
      rsp_old_d = flags[win_idx];
      rsp_err_d = (win_op == OP_ILL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_old_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_old_q   <= rsp_old_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A reset arriving while a response is pending discards it immediately.
  assign bus.rsp_valid = rsp_valid_q && !reset;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_old   = rsp_old_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef SR_FLAG_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (grant && win_op == OP_ILL && err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
